// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/op widths, op-code constants and the arbiter state type.
package alu_pkg;
  localparam int ALU_OP_W   = 3;
  localparam int ALU_DATA_W = 32;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } arb_state_e;
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/sub wrap modulo 2^32, unused op codes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   i_op,
  input  logic [ALU_DATA_W-1:0] i_a,
  input  logic [ALU_DATA_W-1:0] i_b,
  output logic [ALU_DATA_W-1:0] o_result
);
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      default: o_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// N-requester front end to one shared ALU with a single registered result slot.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins grant instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ALU_DATA_W-1:0]   req_a,
  input  logic [N_REQ*ALU_DATA_W-1:0]   req_b,
  input  logic [N_REQ*ALU_OP_W-1:0]     req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [ALU_DATA_W-1:0]         rsp_result,
  output logic                          o_dbg_state
);
  // Handshake: a channel transfers on a cycle where its valid and ready are both
  // high at the rising edge; ready never depends on the requester's own data.

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [ALU_DATA_W-1:0]   r_rsp_result;
  logic [ID_W-1:0]         r_rsp_id;

  logic                    w_can_grant;
  logic                    w_grant_any;
  logic [N_REQ-1:0]        w_grant_oh;
  logic [ID_W-1:0]         w_grant_idx;
  logic                    w_req_xfer;
  logic [ALU_DATA_W-1:0]   w_alu_a;
  logic [ALU_DATA_W-1:0]   w_alu_b;
  logic [ALU_OP_W-1:0]     w_alu_op;
  logic [ALU_DATA_W-1:0]   w_alu_result;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         r_last_grant;
`endif

  // The slot can be refilled when empty, or when it drains this same cycle.
  assign w_can_grant = !rst && ((r_state == ST_IDLE) || rsp_ready);

  always_comb begin
    int w_idx;
    w_idx       = 0;
    w_grant_any = 1'b0;
    w_grant_oh  = '0;
    w_grant_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !w_grant_any) begin
        w_grant_any   = 1'b1;
        w_grant_oh[i] = 1'b1;
        w_grant_idx   = ID_W'(i);
      end
    end
`else
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = (int'(r_last_grant) + k) % N_REQ;
      if (req_valid[w_idx] && !w_grant_any) begin
        w_grant_any       = 1'b1;
        w_grant_oh[w_idx] = 1'b1;
        w_grant_idx       = ID_W'(w_idx);
      end
    end
`endif
  end

  assign req_ready  = w_can_grant ? w_grant_oh : '0;
  assign w_req_xfer = w_can_grant && w_grant_any;

  assign w_alu_a  = req_a[ALU_DATA_W*w_grant_idx +: ALU_DATA_W];
  assign w_alu_b  = req_b[ALU_DATA_W*w_grant_idx +: ALU_DATA_W];
  assign w_alu_op = req_op[ALU_OP_W*w_grant_idx +: ALU_OP_W];

  alu u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req_xfer) w_state_nxt = ST_FULL;
      ST_FULL: if (rsp_ready && !w_req_xfer) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_xfer) begin
        r_rsp_result <= w_alu_result;
        r_rsp_id     <= w_grant_idx;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset pointer sits on the last index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ID_W'(N_REQ - 1);
    end else if (w_req_xfer) begin
      r_last_grant <= w_grant_idx;
    end
  end
`endif

  assign rsp_valid   = (r_state == ST_FULL);
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign o_dbg_state = (r_state == ST_FULL);
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for ALU ops plus arbitration/backpressure/reset sequences.
module tb_alu_arbiter;
  localparam int N_REQ = 2;
  localparam int ID_W  = 2;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ*3-1:0]  req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [31:0]       rsp_result;
  logic              dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  alu_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int sel, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op);
    req_a[32*sel +: 32] = a;
    req_b[32*sel +: 32] = b;
    req_op[3*sel +: 3]  = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  exp_id;
    logic [31:0] exp_res;
    logic [33:0] exp_ent;

    vecs[0]  = '{0, 32'd5,          32'd3,          3'b000, 32'd8};
    vecs[1]  = '{0, 32'd0,          32'd1,          3'b001, 32'hFFFF_FFFF};
    vecs[2]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'b000, 32'h0};
    vecs[3]  = '{1, 32'hF0F0_F0F0,  32'hFF00_FF00,  3'b010, 32'hF000_F000};
    vecs[4]  = '{0, 32'hF0F0_F0F0,  32'h0F0F_0000,  3'b011, 32'hFFFF_F0F0};
    vecs[5]  = '{1, 32'hAAAA_AAAA,  32'hFFFF_0000,  3'b100, 32'h5555_AAAA};
    vecs[6]  = '{0, 32'd12,         32'd34,         3'b101, 32'h0};
    vecs[7]  = '{1, 32'd12,         32'd34,         3'b110, 32'h0};
    vecs[8]  = '{0, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'h0};
    vecs[9]  = '{1, 32'd100,        32'd250,        3'b001, 32'hFFFF_FF6A};
    vecs[10] = '{0, 32'h7FFF_FFFF,  32'd1,          3'b000, 32'h8000_0000};
    vecs[11] = '{1, 32'h1234_5678,  32'h1111_1111,  3'b000, 32'h2345_6789};

    // Reset with requests pending: nothing may be granted while rst is high.
    rst = 1'b1; rsp_ready = 1'b0; req_valid = 2'b11;
    req_a = '0; req_b = '0; req_op = '0;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;

    // No requests: nothing granted, stays idle.
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);
    tick();
    check("idle_state", 32'(dbg_state), 32'h0);

    // Both requesters continuously valid, consumer always ready.
    drive_req(0, 32'd1, 32'd1, 3'b000);
    drive_req(1, 32'd10, 32'd3, 3'b001);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_id  = FIXED ? 2'd0 : 2'(k % 2);
      exp_res = (exp_id == 2'd0) ? 32'd2 : 32'd7;
      #1;
      check("rr_ready", 32'(req_ready), 32'(2'b01 << exp_id));
      exp_q.push_back({exp_id, exp_res});
      tick();
      check("rr_valid", 32'(rsp_valid), 32'h1);
      exp_ent = exp_q.pop_front();
      check("rr_id", 32'(rsp_id), 32'(exp_ent[33:32]));
      check("rr_result", rsp_result, exp_ent[31:0]);
    end
    req_valid = 2'b00;
    tick();
    check("rr_drain", 32'(rsp_valid), 32'h0);

    // Single-requester ALU vectors, back to back.
    for (int i = 0; i < 12; i++) begin
      req_valid = 2'b00;
      drive_req(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].op);
      req_valid = 2'(1 << vecs[i].sel);
      rsp_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(1 << vecs[i].sel));
      tick();
      check($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'h1);
      check($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(vecs[i].sel));
      check($sformatf("vec%0d_result", i), rsp_result, vecs[i].exp);
    end
    req_valid = 2'b00;
    tick();
    check("vec_drain", 32'(rsp_valid), 32'h0);

    // Backpressure: 0 - 1 held while the consumer stalls for 3 cycles.
    drive_req(0, 32'd0, 32'd1, 3'b001);
    drive_req(1, 32'd7, 32'd2, 3'b000);
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_result", rsp_result, 32'hFFFF_FFFF);
      check("bp_id", 32'(rsp_id), 32'h0);
      tick();
    end
    check("bp_held_result", rsp_result, 32'hFFFF_FFFF);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), FIXED ? 32'h1 : 32'h2);
    tick();
    check("bp_refill_valid", 32'(rsp_valid), 32'h1);
    check("bp_refill_id", 32'(rsp_id), FIXED ? 32'h0 : 32'h1);
    check("bp_refill_result", rsp_result, FIXED ? 32'hFFFF_FFFF : 32'd9);
    req_valid = 2'b00;
    tick();
    check("bp_drain", 32'(rsp_valid), 32'h0);

    // Reset while a result is held; pointer must restart at requester 0.
    drive_req(0, 32'd5, 32'd3, 3'b000);
    drive_req(1, 32'd7, 32'd2, 3'b000);
    req_valid = 2'b01; rsp_ready = 1'b0;
    tick();
    check("mid_full", 32'(dbg_state), 32'h1);
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_result", rsp_result, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    check("post_rst_id", 32'(rsp_id), 32'h0);
    check("post_rst_result", rsp_result, 32'd8);
    req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters; legal range 2..4.
REQ-002 Parameter ID_W, default 2: width of requester index; SHALL be >= clog2(N_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester operation valid.
REQ-006 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-007 req_a  input  N_REQ*32  operand A, requester i at bits [32*i+31:32*i].
REQ-008 req_b  input  N_REQ*32  operand B, same packing.
REQ-009 req_op  input  N_REQ*3  ALU op, requester i at bits [3*i+2:3*i].
REQ-010 rsp_valid  output  1  result register holds valid result.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  ID_W  index of requester that issued the result.
REQ-013 rsp_result  output  32  ALU result.

Function
REQ-014 Transfer on a request channel SHALL occur when req_valid[i] and req_ready[i] are both high; transfer on the response channel when rsp_valid and rsp_ready are both high.
REQ-015 State machine SHALL have two states: IDLE (result register empty) and FULL (result held).
REQ-016 req_ready SHALL be nonzero only when state is IDLE, or state is FULL with rsp_ready high (drain and refill in the same cycle).
REQ-017 When a grant is possible, the arbiter SHALL grant exactly one valid requester, combinationally, selected round-robin starting from the index after last_grant.
REQ-018 last_grant SHALL update to the granted index only on a request transfer; it SHALL NOT change while no transfer occurs.
REQ-019 Granted operands and op SHALL feed the shared alu; result, granted index and valid SHALL be registered, giving latency exactly 1 cycle from request transfer to rsp_valid.
REQ-020 Op encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, others result 0; add/sub wrap modulo 2^32, no flags.
REQ-021 Transitions: IDLE->FULL on request transfer; FULL->IDLE on response transfer without new request transfer; FULL->FULL on response with simultaneous request transfer, or while rsp_ready low.
REQ-022 While FULL and rsp_ready low, rsp_result and rsp_id SHALL be held stable.
REQ-023 Requester whose req_valid drops without transfer SHALL be skipped; no request is lost or duplicated.
REQ-024 No valid requests: req_ready SHALL be all zero and state and pointer unchanged.

Reset
REQ-025 On rst high at a clock edge: state IDLE, rsp_valid 0, rsp_result 0, rsp_id 0, last_grant N_REQ-1 (so requester 0 wins first).
REQ-026 rst SHALL take priority over any simultaneous transfer; a held result is discarded.
REQ-027 req_ready SHALL be all zero during any cycle rst is high.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN: when defined, grant SHALL be fixed priority, lowest valid index wins, last_grant unused; when undefined, round-robin per REQ-017.

Structure
REQ-029 Shared package alu_pkg SHALL hold the op-code constants (ALU_ADD..ALU_XOR), op width 3 and data width 32.
REQ-030 Existing alu module SHALL be instantiated as the sole sub-module; the arbiter SHALL NOT duplicate ALU logic.

Verification
REQ-031 Single op: req0 a=5 b=3 op=000 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=8.
REQ-032 Round-robin: req0 and req1 continuously valid, rsp_ready=1 -> rsp_id sequence 0,1,0,1 with one result per cycle.
REQ-033 Backpressure: rsp_ready=0 for 3 cycles with result 0xFFFFFFFF (a=0 b=1 op=001) held -> req_ready=0, rsp_result stable, released on rsp_ready=1.
REQ-034 Wrap/illegal op: a=0xFFFFFFFF b=1 op=000 -> 0; op=111 -> 0.
REQ-035 Reset mid-operation: rst during FULL -> next cycle rsp_valid=0, then req0 and req1 both valid -> requester 0 granted first.
REQ-036 With ALU_ARB_FIXED_PRIO_EN: req0 and req1 continuously valid -> rsp_id always 0.
